// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR test-pattern generator and related BIST blocks.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_FIB    = 1'b0;
  localparam logic MODE_GALOIS = 1'b1;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 32;

  // Primitive polynomials, x^WIDTH term implied
  localparam logic [3:0]  POLY4  = 4'b0011;          // x^4+x+1
  localparam logic [7:0]  POLY8  = 8'h1D;            // x^8+x^4+x^3+x^2+1
  localparam logic [15:0] POLY16 = 16'h002D;         // x^16+x^5+x^3+x^2+1
  localparam logic [31:0] POLY32 = 32'h0000_00C5;    // x^32+x^7+x^6+x^2+1

endpackage

// File: rtl/lfsr_tpg_if.sv
// Control/pattern bus between the BIST controller (master) and the pattern generator (slave).
interface lfsr_tpg_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             enable;
  logic             mode;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic [CNT_W-1:0] pat_count;
  logic [WIDTH-1:0] pattern;
  logic             pattern_valid;
  logic             busy;
  logic             done;
  logic             lockup_err;

  modport master (
    output start, abort, enable, mode, seed_load, seed_in, pat_count,
    input  pattern, pattern_valid, busy, done, lockup_err
  );

  modport slave (
    input  start, abort, enable, mode, seed_load, seed_in, pat_count,
    output pattern, pattern_valid, busy, done, lockup_err
  );
endinterface

// File: rtl/lfsr_next.sv
// Combinational LFSR step: Fibonacci or Galois, both shifting left.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = POLY4
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  output logic [WIDTH-1:0] next_c
);

  logic [WIDTH-1:0] taps_rev;
  logic             fb;

  // Fibonacci taps are mirrored so the shift-left register realises the same polynomial
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign taps_rev[i] = TAPS[WIDTH-1-i];
  end

  assign fb = ^(state & taps_rev);

  always_comb begin
    next_c = {state[WIDTH-2:0], fb};
    if (mode == MODE_GALOIS) begin
      next_c = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/lfsr_tpg.sv
// BIST pattern generator: run FSM, pattern counter and seed register around lfsr_next.
module lfsr_tpg
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = POLY4,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int unsigned      CNT_W = 16
) (
  input logic       clk,
  input logic       rst,
  lfsr_tpg_if.slave bus
);

  state_e           state;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic             busy_q;
  logic             done_q;
  logic             lockup_q;
  logic [WIDTH-1:0] lfsr_nxt;

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next (
    .state  (lfsr_q),
    .mode   (mode_q),
    .next_c (lfsr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lfsr_q   <= SEED;
      seed_q   <= SEED;
      cnt      <= '0;
      mode_q   <= MODE_FIB;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
      case (state)
        IDLE: begin
          // start wins over seed_load; a simultaneous load is dropped
          if (bus.start) begin
            lfsr_q <= seed_q;
            cnt    <= bus.pat_count;
            mode_q <= bus.mode;
            if (bus.pat_count == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end else if (bus.seed_load) begin
            if (bus.seed_in != '0) begin
              seed_q <= bus.seed_in;
            end else begin
              seed_q   <= SEED;
              lockup_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.enable) begin
            lfsr_q <= lfsr_nxt;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pattern       = lfsr_q;
  assign bus.pattern_valid = busy_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.lockup_err    = lockup_q;

endmodule

// File: tb/tb_lfsr_tpg.sv
// Directed and randomized checks of lfsr_tpg against a polynomial-arithmetic reference model.
module tb_lfsr_tpg;
  import lfsr_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 16;
  localparam logic [3:0]  TAPS  = 4'b0011;
  localparam logic [3:0]  SEED  = 4'b0001;
  localparam int          TAPS_I = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lfsr_tpg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  lfsr_tpg #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] mdl_seed = SEED;
  logic [3:0] got[$];
  logic [3:0] trace[$];
  logic [3:0] fib_exp [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                               4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0] gal_exp [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                               4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Galois: multiply by x modulo P(x). Fibonacci: new bit is the parity of the recurrence taps.
  function automatic logic [3:0] mdl_next(input logic [3:0] s, input logic m);
    int v;
    int par;
    v = int'(s);
    if (m) begin
      v = v * 2;
      if (v >= 16) v = v ^ (16 + TAPS_I);
    end else begin
      par = 0;
      for (int i = 0; i < 4; i++)
        if (((TAPS_I >> i) & 1) != 0) par = par ^ ((v >> (3 - i)) & 1);
      v = ((v * 2) % 16) | par;
    end
    return 4'(v);
  endfunction

  task automatic load_seed(input logic [3:0] s);
    bus.seed_load = 1'b1;
    bus.seed_in   = s;
    @(negedge clk);
    bus.seed_load = 1'b0;
    chk("lockup_pulse", 32'(bus.lockup_err), 32'(s == 4'h0));
    mdl_seed = (s == 4'h0) ? SEED : s;
    @(negedge clk);
    chk("lockup_clear", 32'(bus.lockup_err), 32'd0);
  endtask

  task automatic run(input logic m, input int n, input bit use_mask, input logic [31:0] mask,
                     input int abort_cyc, input bit noise, input bit also_load);
    logic [3:0] exp;
    int delivered;
    int cyc;
    logic en;
    got.delete();
    trace.delete();
    bus.start     = 1'b1;
    bus.mode      = m;
    bus.pat_count = 16'(n);
    bus.seed_load = also_load;
    bus.seed_in   = 4'($urandom_range(15));
    @(negedge clk);
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    chk("start_no_lockup", 32'(bus.lockup_err), 32'd0);
    exp = mdl_seed;
    if (n == 0) begin
      chk("zero_done", 32'(bus.done), 32'd1);
      chk("zero_busy", 32'(bus.busy), 32'd0);
      chk("zero_valid", 32'(bus.pattern_valid), 32'd0);
      @(negedge clk);
      chk("zero_done_end", 32'(bus.done), 32'd0);
      chk("zero_busy_end", 32'(bus.busy), 32'd0);
      chk("zero_pattern", 32'(bus.pattern), 32'(exp));
      return;
    end
    delivered = 0;
    cyc = 0;
    while (delivered < n && cyc < 1000) begin
      chk("run_busy", 32'(bus.busy), 32'd1);
      chk("run_valid", 32'(bus.pattern_valid), 32'd1);
      chk("run_pattern", 32'(bus.pattern), 32'(exp));
      chk("run_no_done", 32'(bus.done), 32'd0);
      chk("run_no_lockup", 32'(bus.lockup_err), 32'd0);
      trace.push_back(bus.pattern);
      if (cyc == abort_cyc) begin
        bus.abort = 1'b1;
        bus.enable = 1'b1;
        bus.start = 1'b0;
        bus.seed_load = 1'b0;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.enable = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_no_done", 32'(bus.done), 32'd0);
        chk("abort_hold", 32'(bus.pattern), 32'(exp));
        @(negedge clk);
        chk("abort_no_done2", 32'(bus.done), 32'd0);
        chk("abort_idle", 32'(bus.busy), 32'd0);
        return;
      end
      if (use_mask) en = (cyc < 32) ? mask[cyc] : 1'b1;
      else          en = ($urandom_range(99) < 70);
      bus.enable = en;
      bus.start = noise;
      bus.seed_load = noise & 1'($urandom_range(1));
      bus.seed_in = 4'($urandom_range(15));
      if (en) got.push_back(bus.pattern);
      @(negedge clk);
      if (en) begin
        exp = mdl_next(exp, m);
        delivered++;
      end
      cyc++;
    end
    bus.enable = 1'b0;
    bus.seed_load = 1'b0;
    chk("delivered", 32'(delivered), 32'(n));
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_valid", 32'(bus.pattern_valid), 32'd0);
    chk("done_pattern", 32'(bus.pattern), 32'(exp));
    @(negedge clk);
    bus.start = 1'b0;
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_pattern", 32'(bus.pattern), 32'(exp));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.enable = 1'b0;
    bus.mode = MODE_FIB;
    bus.seed_load = 1'b0;
    bus.seed_in = 4'h0;
    bus.pat_count = 16'd0;

    // reset values
    @(negedge clk);
    chk("rst_pattern", 32'(bus.pattern), 32'(SEED));
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.pattern_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_lockup", 32'(bus.lockup_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 32'(bus.busy), 32'd0);

    // Fibonacci full period plus one
    run(MODE_FIB, 16, 1'b1, 32'hFFFF_FFFF, -1, 1'b0, 1'b0);
    chk("fib_len", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("fib_seq", 32'(got[i]), 32'(fib_exp[i]));

    // Galois one period
    run(MODE_GALOIS, 15, 1'b1, 32'hFFFF_FFFF, -1, 1'b0, 1'b0);
    chk("gal_len", 32'(got.size()), 32'd15);
    for (int i = 0; i < 15 && i < got.size(); i++) chk("gal_seq", 32'(got[i]), 32'(gal_exp[i]));
    chk("gal_idle_pattern", 32'(bus.pattern), 32'h1);

    // enable stall 1,0,0,1
    run(MODE_FIB, 6, 1'b1, 32'hFFFF_FFF9, -1, 1'b0, 1'b0);
    chk("stall_c0", 32'(trace[0]), 32'h1);
    chk("stall_c1", 32'(trace[1]), 32'h2);
    chk("stall_c2", 32'(trace[2]), 32'h2);
    chk("stall_c3", 32'(trace[3]), 32'h2);
    chk("stall_c4", 32'(trace[4]), 32'h4);
    chk("stall_count", 32'(got.size()), 32'd6);

    // seed handling
    load_seed(4'h0);
    run(MODE_FIB, 3, 1'b1, 32'hFFFF_FFFF, -1, 1'b0, 1'b0);
    chk("zero_seed_first", 32'(got[0]), 32'h1);
    load_seed(4'hA);
    run(MODE_FIB, 3, 1'b1, 32'hFFFF_FFFF, -1, 1'b0, 1'b0);
    chk("seedA_0", 32'(got[0]), 32'hA);
    chk("seedA_1", 32'(got[1]), 32'h5);
    chk("seedA_2", 32'(got[2]), 32'hB);

    // edge cases: zero count, abort in 3rd RUN cycle, start/seed_load noise during RUN
    run(MODE_FIB, 0, 1'b1, 32'hFFFF_FFFF, -1, 1'b0, 1'b0);
    run(MODE_FIB, 8, 1'b1, 32'hFFFF_FFFF, 2, 1'b0, 1'b0);
    run(MODE_GALOIS, 5, 1'b1, 32'hFFFF_FFFF, -1, 1'b1, 1'b1);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(3) == 0) load_seed(4'($urandom_range(15)));
      run(1'($urandom_range(1)), int'($urandom_range(40)), 1'b0, 32'h0,
          ($urandom_range(4) == 0) ? int'($urandom_range(30)) : -1,
          1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    // asynchronous reset mid-run
    load_seed(4'hA);
    bus.start = 1'b1;
    bus.mode = MODE_FIB;
    bus.pat_count = 16'd20;
    @(negedge clk);
    bus.start = 1'b0;
    bus.enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_pattern", 32'(bus.pattern), 32'hB);
    #2 rst = 1'b1;
    #1;
    chk("async_pattern", 32'(bus.pattern), 32'(SEED));
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_valid", 32'(bus.pattern_valid), 32'd0);
    chk("async_done", 32'(bus.done), 32'd0);
    chk("async_lockup", 32'(bus.lockup_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.enable = 1'b0;
    mdl_seed = SEED;
    run(MODE_FIB, 4, 1'b1, 32'hFFFF_FFFF, -1, 1'b0, 1'b0);
    chk("post_rst_first", 32'(got[0]), 32'h1);
    chk("post_rst_last", 32'(got[3]), 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
